uart_tx_feeder: RTL and testbench

UART_TX_FEEDER -- requirements
Module: uart_tx_feeder

---
 rtl/uart_tx_feeder_if.sv | 28 ++
 rtl/uart_tx_feeder.sv | 115 +++++++++++
 tb/tb_uart_tx_feeder.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_feeder_if.sv
// Signal bundle between a byte producer, the UART TX feeder and the UART transmitter.
// The feeder connects through the slave modport; the producer side uses master.
interface uart_tx_feeder_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 8
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic [DATA_WIDTH-1:0] WR_DATA;
    logic                  WR_EN;
    logic                  FULL;
    logic                  EMPTY;
    logic [CW-1:0]         COUNT;
    logic                  OVERFLOW;
    logic [DATA_WIDTH-1:0] TX_P_DATA;
    logic                  TX_DATA_VALID;
    logic                  TX_BUSY;

    modport master (
        output WR_DATA, WR_EN, TX_BUSY,
        input  FULL, EMPTY, COUNT, OVERFLOW, TX_P_DATA, TX_DATA_VALID
    );

    modport slave (
        input  WR_DATA, WR_EN, TX_BUSY,
        output FULL, EMPTY, COUNT, OVERFLOW, TX_P_DATA, TX_DATA_VALID
    );
endinterface

// File: rtl/uart_tx_feeder.sv
// Byte FIFO that feeds a UART transmitter: launches one byte per one-cycle valid pulse
// and waits for the transmitter's busy flag to rise and fall before the next launch.
module uart_tx_feeder #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 8
) (
    input logic             CLK,
    input logic             RST,
    uart_tx_feeder_if.slave bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef enum logic [1:0] {StIdle, StIssue, StWaitHi, StWaitLo} state_e;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    state_e                state_q, state_d;
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  full_q, full_d;
    logic                  empty_q, empty_d;
    logic                  ovf_q, ovf_d;
    logic                  valid_q, valid_d;
    logic [DATA_WIDTH-1:0] pdata_q, pdata_d;
    logic                  guard_q, guard_d;
    logic                  push, pop;

    always_comb begin
        push     = bus.WR_EN && !full_q;
        pop      = (state_q == StIdle) && !empty_q && !bus.TX_BUSY;
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;

        unique case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        full_d  = (count_d == CW'(DEPTH));
        empty_d = (count_d == '0);
        // A rejected write is flagged even when a pop frees a slot on the same edge.
        ovf_d   = bus.WR_EN && full_q;

        state_d = state_q;
        guard_d = guard_q;
        valid_d = 1'b0;
        pdata_d = pdata_q;
        unique case (state_q)
            StIdle: begin
                if (pop) begin
                    state_d = StIssue;
                    valid_d = 1'b1;
                    pdata_d = mem_q[rd_ptr_q];
                end
            end
            StIssue: begin
                state_d = StWaitHi;
                guard_d = 1'b0;
            end
            StWaitHi: begin
                // Busy never rising for two cycles means the byte is treated as consumed.
                if (bus.TX_BUSY) begin
                    state_d = StWaitLo;
                end else if (guard_q) begin
                    state_d = StIdle;
                end else begin
                    guard_d = 1'b1;
                end
            end
            StWaitLo: begin
                if (!bus.TX_BUSY) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= StIdle;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            ovf_q    <= 1'b0;
            valid_q  <= 1'b0;
            pdata_q  <= '0;
            guard_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            ovf_q    <= ovf_d;
            valid_q  <= valid_d;
            pdata_q  <= pdata_d;
            guard_q  <= guard_d;
            if (push) begin
                mem_q[wr_ptr_q] <= bus.WR_DATA;
            end
        end
    end

    assign bus.FULL          = full_q;
    assign bus.EMPTY         = empty_q;
    assign bus.COUNT         = count_q;
    assign bus.OVERFLOW      = ovf_q;
    assign bus.TX_P_DATA     = pdata_q;
    assign bus.TX_DATA_VALID = valid_q;
endmodule

// File: tb/tb_uart_tx_feeder.sv
// Self-checking bench for uart_tx_feeder: vector table for reset/fill/overflow, a byte
// scoreboard checked on every launch, and a simple UART transmitter busy model.
module tb_uart_tx_feeder;
    localparam int unsigned DW      = 8;
    localparam int unsigned DEPTH   = 8;
    localparam int unsigned CW      = $clog2(DEPTH) + 1;
    localparam int          DEPTH_I = DEPTH;

    logic CLK = 1'b0;
    logic RST;
    always #5 CLK = ~CLK;

    uart_tx_feeder_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus ();
    uart_tx_feeder #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (.CLK(CLK), .RST(RST), .bus(bus));

    typedef struct {
        logic          rst;
        logic          wr;
        logic [DW-1:0] d;
        logic [CW-1:0] cnt;
        logic          full;
        logic          empty;
        logic          ovf;
        logic          valid;
    } vec_t;

    vec_t          tbl [11];
    logic [DW-1:0] sb [$];
    int            checks = 0;
    int            errors = 0;
    int            mdl_cnt = 0;
    int            cyc = 0;
    int            launches = 0;
    int            last_launch = 0;
    int            prev_launch = 0;
    int            busy_cnt = 0;
    int            base = 0;
    logic          exp_ovf = 1'b0;
    logic          prev_valid = 1'b0;
    logic          uart_en = 1'b0;
    logic          busy_force = 1'b1;
    logic          pend = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Every launch must match the oldest accepted byte and respect the busy handshake.
    task automatic monitor();
        if (bus.TX_DATA_VALID) begin
            launches++;
            prev_launch = last_launch;
            last_launch = cyc;
            chk("launch_while_busy", int'(bus.TX_BUSY), 0);
            chk("valid_width", int'(prev_valid), 0);
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_launch: got data 0x%0h, required no launch (cycle %0d)",
                         bus.TX_P_DATA, cyc);
            end else begin
                chk("launch_data", int'(bus.TX_P_DATA), int'(sb.pop_front()));
                mdl_cnt--;
            end
        end
        prev_valid = bus.TX_DATA_VALID;
    endtask

    // Transmitter model: busy rises one cycle after the valid pulse and lasts 10 cycles.
    task automatic drive_busy();
        if (uart_en) begin
            if (busy_cnt > 0) busy_cnt--;
            if (pend) begin
                busy_cnt = 10;
                pend     = 1'b0;
            end
            if (bus.TX_DATA_VALID) pend = 1'b1;
            bus.TX_BUSY = (busy_cnt != 0);
        end else begin
            busy_cnt    = 0;
            pend        = 1'b0;
            bus.TX_BUSY = busy_force;
        end
    endtask

    task automatic step(input logic rst, input logic wr, input logic [DW-1:0] d);
        RST         = rst;
        bus.WR_EN   = wr;
        bus.WR_DATA = d;
        @(posedge CLK);
        cyc++;
        if (rst) begin
            sb.delete();
            mdl_cnt = 0;
            exp_ovf = 1'b0;
        end else begin
            exp_ovf = wr && (mdl_cnt == DEPTH_I);
            if (wr && mdl_cnt < DEPTH_I) begin
                sb.push_back(d);
                mdl_cnt++;
            end
        end
        @(negedge CLK);
        monitor();
        drive_busy();
        chk("overflow", int'(bus.OVERFLOW), int'(exp_ovf));
        chk("count", int'(bus.COUNT), mdl_cnt);
        chk("empty", int'(bus.EMPTY), int'(mdl_cnt == 0));
        chk("full", int'(bus.FULL), int'(mdl_cnt == DEPTH_I));
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 1'b0, '0);
    endtask

    task automatic drain(input int limit, input int tail);
        for (int k = 0; k < limit && mdl_cnt != 0; k++) step(1'b0, 1'b0, '0);
        chk("drain_remaining", mdl_cnt, 0);
        idle(tail);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required to finish", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        RST         = 1'b1;
        bus.WR_EN   = 1'b0;
        bus.WR_DATA = '0;
        bus.TX_BUSY = 1'b1;

        // Reset, fill to 8 with busy held high, then one rejected write.
        tbl[0] = '{1'b1, 1'b0, 8'h00, CW'(0), 1'b0, 1'b1, 1'b0, 1'b0};
        for (int i = 1; i <= 8; i++)
            tbl[i] = '{1'b0, 1'b1, 8'(i), CW'(i), (i == 8), 1'b0, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, 1'b1, 8'h09, CW'(8), 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[10] = '{1'b0, 1'b0, 8'h00, CW'(8), 1'b1, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 11; i++) begin
            step(tbl[i].rst, tbl[i].wr, tbl[i].d);
            chk($sformatf("tbl%0d_count", i), int'(bus.COUNT), int'(tbl[i].cnt));
            chk($sformatf("tbl%0d_full", i), int'(bus.FULL), int'(tbl[i].full));
            chk($sformatf("tbl%0d_empty", i), int'(bus.EMPTY), int'(tbl[i].empty));
            chk($sformatf("tbl%0d_ovf", i), int'(bus.OVERFLOW), int'(tbl[i].ovf));
            chk($sformatf("tbl%0d_valid", i), int'(bus.TX_DATA_VALID), int'(tbl[i].valid));
        end

        // Release the transmitter: exactly 0x01..0x08 go out, 0x09 never does.
        uart_en = 1'b1;
        base    = launches;
        drain(300, 16);
        chk("fill_launches", launches - base, 8);

        // Single byte with busy tied low: launch one edge after the write edge.
        uart_en    = 1'b0;
        busy_force = 1'b0;
        idle(2);
        step(1'b0, 1'b1, 8'hA5);
        chk("single_no_fallthrough", int'(bus.TX_DATA_VALID), 0);
        idle(1);
        chk("single_valid", int'(bus.TX_DATA_VALID), 1);
        chk("single_data", int'(bus.TX_P_DATA), 32'hA5);
        chk("single_count", int'(bus.COUNT), 0);
        chk("single_empty", int'(bus.EMPTY), 1);
        idle(1);
        chk("single_valid_drop", int'(bus.TX_DATA_VALID), 0);
        chk("single_data_hold", int'(bus.TX_P_DATA), 32'hA5);
        idle(4);

        // Guard timeout: busy never rises, next launch follows ISSUE + 2 WAIT_HI + IDLE.
        base = launches;
        step(1'b0, 1'b1, 8'hB1);
        step(1'b0, 1'b1, 8'hB2);
        for (int k = 0; k < 20 && (launches - base) < 2; k++) idle(1);
        chk("guard_launches", launches - base, 2);
        chk("guard_gap", last_launch - prev_launch, 4);
        idle(4);

        // Push and pop on the same edge with three queued bytes.
        busy_force = 1'b1;
        idle(1);
        step(1'b0, 1'b1, 8'h31);
        step(1'b0, 1'b1, 8'h32);
        step(1'b0, 1'b1, 8'h33);
        chk("pp_pre_count", int'(bus.COUNT), 3);
        busy_force = 1'b0;
        idle(1);
        step(1'b0, 1'b1, 8'h34);
        chk("pp_count", int'(bus.COUNT), 3);
        chk("pp_ovf", int'(bus.OVERFLOW), 0);
        chk("pp_valid", int'(bus.TX_DATA_VALID), 1);
        drain(100, 6);

        // Ordering and pointer wrap with the transmitter model and interleaved writes.
        uart_en = 1'b1;
        idle(1);
        base = launches;
        for (int i = 0; i < 12; i++) begin
            step(1'b0, 1'b1, 8'(8'h10 + i));
            idle(4);
        end
        drain(300, 16);
        chk("wrap_launches", launches - base, 12);

        // Reset during ISSUE with four bytes still queued.
        uart_en    = 1'b0;
        busy_force = 1'b1;
        idle(1);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 8'(8'h41 + i));
        busy_force = 1'b0;
        idle(1);
        idle(1);
        chk("rst_pre_valid", int'(bus.TX_DATA_VALID), 1);
        chk("rst_pre_count", int'(bus.COUNT), 4);
        step(1'b1, 1'b0, '0);
        chk("rst_valid", int'(bus.TX_DATA_VALID), 0);
        chk("rst_count", int'(bus.COUNT), 0);
        chk("rst_empty", int'(bus.EMPTY), 1);
        chk("rst_pdata", int'(bus.TX_P_DATA), 0);
        base = launches;
        idle(20);
        chk("rst_no_launch", launches - base, 0);
        step(1'b0, 1'b1, 8'h5A);
        idle(2);
        chk("rst_recover_launch", launches - base, 1);
        idle(4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
